// File: rtl/bp_cce_pending_sched_if.sv
// rtl/bp_cce_pending_sched_if.sv - requester handshake and table write-side bundle for bp_cce_pending_sched
//
// Signals
//   req_v      requester -> sched  per-requester op valid
//   req_wg     requester -> sched  per-requester way group, requester k in slice k
//   req_op     requester -> sched  per-requester op: 0 inc, 1 dec, 2 clear, 3 reserved
//   req_ready  sched -> requester  one-hot grant
//   w_v        sched -> tracer     table write this cycle (requester ops only)
//   w_wg       sched -> tracer     written way group
//   w_val      sched -> tracer     written value
// Modports: master (requester/tracer side), slave (scheduler side).
interface bp_cce_pending_sched_if
  #(parameter int num_way_groups_p = 64
   ,parameter int width_p          = 3
   ,parameter int num_req_p        = 3
   );

   localparam int lg_num_way_groups_lp = (num_way_groups_p > 1) ? $clog2(num_way_groups_p) : 1;

   logic [num_req_p-1:0]                      req_v;
   logic [num_req_p*lg_num_way_groups_lp-1:0] req_wg;
   logic [num_req_p*2-1:0]                    req_op;
   logic [num_req_p-1:0]                      req_ready;
   logic                                      w_v;
   logic [lg_num_way_groups_lp-1:0]           w_wg;
   logic [width_p-1:0]                        w_val;

   modport master (output req_v, req_wg, req_op, input req_ready, w_v, w_wg, w_val);
   modport slave  (input req_v, req_wg, req_op, output req_ready, w_v, w_wg, w_val);

endinterface

// File: rtl/bp_cce_pending_sched.sv
// rtl/bp_cce_pending_sched.sv - round-robin scheduler for the CCE pending-counter table
//
// Purpose: arbitrates inc/dec/clear ops from num_req_p requesters onto the shared
// per-way-group pending-counter table, one op per cycle, applied as a registered
// read-modify-write (stage S1). Exposes a pending-bit read port for decode.
//
// Ports
//   clk_i        clock
//   reset_n_i    asynchronous active-low reset
//   bus          requester handshake + write-side outputs (slave modport)
//   rd_wg_i      read-port way group
//   pending_o    counter[rd_wg_i] != 0 (0 during INIT)
//   init_done_o  table initialized, grants enabled
//   err_o        one-cycle pulse on saturation or reserved op
//
// Optional feature macro: BP_CCE_PENDING_BYPASS_EN
//   defined   - pending_o reflects the S1 write being committed this cycle
//   undefined - pending_o reads the committed table only
module bp_cce_pending_sched
  #(parameter int num_way_groups_p = 64
   ,parameter int width_p          = 3
   ,parameter int num_req_p        = 3
   ,localparam int lg_num_way_groups_lp = (num_way_groups_p > 1) ? $clog2(num_way_groups_p) : 1
   )
   (input  logic                            clk_i
   ,input  logic                            reset_n_i
   ,bp_cce_pending_sched_if.slave           bus
   ,input  logic [lg_num_way_groups_lp-1:0] rd_wg_i
   ,output logic                            pending_o
   ,output logic                            init_done_o
   ,output logic                            err_o
   );

   localparam int lg_num_req_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;
   localparam logic [lg_num_way_groups_lp-1:0] last_idx_lp = lg_num_way_groups_lp'(num_way_groups_p-1);
   localparam logic [lg_num_req_lp-1:0]        last_req_lp = lg_num_req_lp'(num_req_p-1);
   localparam logic [width_p-1:0]              max_val_lp  = '1;

   typedef enum logic {INIT, RUN} state_e;

   state_e                          state_r, state_n;
   logic [lg_num_way_groups_lp-1:0] idx_r, idx_n;
   logic [lg_num_req_lp-1:0]        ptr_r;
   logic                            s1_v_r;
   logic [lg_num_way_groups_lp-1:0] s1_wg_r;
   logic [1:0]                      s1_op_r;

   // Table contents are deliberately not reset; the INIT sweep zeroes them.
   logic [width_p-1:0] table_r [num_way_groups_p];

   logic [num_req_p-1:0]            grant;
   logic                            grant_v;
   logic [lg_num_req_lp-1:0]        grant_idx;
   logic [lg_num_way_groups_lp-1:0] grant_wg;
   logic [1:0]                      grant_op;
   int                              k;

   logic [width_p-1:0] old_val, new_val;
   logic               op_err;

   // INIT sweeps idx over every entry, then hands over to RUN for good.
   always_comb begin
      state_n = state_r;
      idx_n   = idx_r;
      if (state_r == INIT) begin
         idx_n = idx_r + lg_num_way_groups_lp'(1);
         if (idx_r == last_idx_lp) begin
            state_n = RUN;
            idx_n   = '0;
         end
      end
   end

   // Round-robin search starting at ptr_r; first valid requester wins.
   always_comb begin
      grant     = '0;
      grant_v   = 1'b0;
      grant_idx = '0;
      k         = 0;
      if (state_r == RUN) begin
         for (int i = 0; i < num_req_p; i++) begin
            k = (int'(ptr_r) + i) % num_req_p;
            if (!grant_v && bus.req_v[k]) begin
               grant_v   = 1'b1;
               grant[k]  = 1'b1;
               grant_idx = lg_num_req_lp'(k);
            end
         end
      end
      grant_wg = bus.req_wg[grant_idx*lg_num_way_groups_lp +: lg_num_way_groups_lp];
      grant_op = bus.req_op[grant_idx*2 +: 2];
   end

   // S1 modify: saturating inc/dec, clear, reserved keeps the old value.
   always_comb begin
      old_val = table_r[s1_wg_r];
      new_val = old_val;
      op_err  = 1'b0;
      case (s1_op_r)
         2'd0: if (old_val == max_val_lp) op_err = 1'b1;
               else new_val = old_val + width_p'(1);
         2'd1: if (old_val == '0) op_err = 1'b1;
               else new_val = old_val - width_p'(1);
         2'd2: new_val = '0;
         default: op_err = 1'b1;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_r <= INIT;
         idx_r   <= '0;
         ptr_r   <= '0;
         s1_v_r  <= 1'b0;
         s1_wg_r <= '0;
         s1_op_r <= '0;
      end else begin
         state_r <= state_n;
         idx_r   <= idx_n;
         s1_v_r  <= grant_v;
         if (grant_v) begin
            s1_wg_r <= grant_wg;
            s1_op_r <= grant_op;
            ptr_r   <= (grant_idx == last_req_lp) ? '0 : grant_idx + lg_num_req_lp'(1);
         end
      end
   end

   // Reset clears s1_v_r asynchronously, so an in-flight op never commits.
   always_ff @(posedge clk_i) begin
      if (state_r == INIT)
         table_r[idx_r] <= '0;
      else if (s1_v_r)
         table_r[s1_wg_r] <= new_val;
   end

   always_comb begin
      pending_o = 1'b0;
      if (state_r == RUN) begin
         pending_o = (table_r[rd_wg_i] != '0);
`ifdef BP_CCE_PENDING_BYPASS_EN
         if (s1_v_r && (s1_wg_r == rd_wg_i))
            pending_o = (new_val != '0);
`else
`endif
      end
   end

   assign init_done_o   = (state_r == RUN);
   assign bus.req_ready = grant;
   assign bus.w_v       = s1_v_r;
   assign bus.w_wg      = s1_v_r ? s1_wg_r : '0;
   assign bus.w_val     = s1_v_r ? new_val : '0;
   assign err_o         = s1_v_r & op_err;

endmodule

// File: tb/tb_bp_cce_pending_sched.sv
// tb/tb_bp_cce_pending_sched.sv - directed self-checking bench for bp_cce_pending_sched
module tb_bp_cce_pending_sched;

   logic       clk;
   logic       reset_n;
   logic [5:0] rd_wg;
   logic       pending;
   logic       init_done;
   logic       err;
   int         checks   = 0;
   int         failures = 0;

   bp_cce_pending_sched_if #(.num_way_groups_p(64), .width_p(3), .num_req_p(3)) bus ();

   bp_cce_pending_sched #(.num_way_groups_p(64), .width_p(3), .num_req_p(3)) dut
     (.clk_i(clk)
     ,.reset_n_i(reset_n)
     ,.bus(bus)
     ,.rd_wg_i(rd_wg)
     ,.pending_o(pending)
     ,.init_done_o(init_done)
     ,.err_o(err)
     );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef BP_CCE_PENDING_BYPASS_EN
   localparam logic byp_exp = 1'b1;
`else
   localparam logic byp_exp = 1'b0;
`endif

   task automatic clear_req();
      bus.req_v  = '0;
      bus.req_wg = '0;
      bus.req_op = '0;
   endtask

   task automatic set_req(input int r, input logic [5:0] wg, input logic [1:0] op);
      bus.req_v[r]         = 1'b1;
      bus.req_wg[r*6 +: 6] = wg;
      bus.req_op[r*2 +: 2] = op;
   endtask

   task automatic wait_init(output int cnt);
      cnt = 0;
      while (init_done !== 1'b1 && cnt < 200) begin
         @(negedge clk);
         cnt++;
         if (cnt == 10) begin
            checks++; if (bus.req_ready !== 3'b000) begin failures++; $display("FAIL init_no_grant got=%b exp=000", bus.req_ready); end
         end
      end
   endtask

   task automatic test_reset();
      int cnt;
      clear_req();
      rd_wg   = '0;
      reset_n = 1'b1;
      #2;
      reset_n = 1'b0;
      bus.req_v = 3'b111;
      #1;
      checks++; if (bus.req_ready !== 3'b000) begin failures++; $display("FAIL rst_ready got=%b exp=000", bus.req_ready); end
      checks++; if (init_done !== 1'b0) begin failures++; $display("FAIL rst_init_done got=%b exp=0", init_done); end
      checks++; if (bus.w_v !== 1'b0 || bus.w_wg !== 6'd0 || bus.w_val !== 3'd0) begin failures++; $display("FAIL rst_wside got=%b/%0d/%0d exp=0/0/0", bus.w_v, bus.w_wg, bus.w_val); end
      checks++; if (err !== 1'b0 || pending !== 1'b0) begin failures++; $display("FAIL rst_err_pend got=%b/%b exp=0/0", err, pending); end
      @(negedge clk); @(negedge clk);
      reset_n = 1'b1;
      wait_init(cnt);
      bus.req_v = '0;
      checks++; if (cnt !== 64) begin failures++; $display("FAIL init_len got=%0d exp=64", cnt); end
      // reset pulsed mid-sweep at idx 20
      @(negedge clk); reset_n = 1'b0;
      @(negedge clk); reset_n = 1'b1;
      repeat (20) @(negedge clk);
      reset_n = 1'b0;
      #1;
      checks++; if (init_done !== 1'b0) begin failures++; $display("FAIL midsweep_done got=%b exp=0", init_done); end
      @(negedge clk); reset_n = 1'b1;
      wait_init(cnt);
      checks++; if (cnt !== 64) begin failures++; $display("FAIL restart_len got=%0d exp=64", cnt); end
   endtask

   task automatic test_inc_dec();
      rd_wg = 6'd5;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); clear_req(); set_req(0, 6'd5, 2'd0); #1;
         checks++; if (bus.req_ready !== 3'b001) begin failures++; $display("FAIL inc_ready got=%b exp=001", bus.req_ready); end
         @(posedge clk); #1;
         checks++; if (bus.w_v !== 1'b1 || bus.w_wg !== 6'd5 || bus.w_val !== 3'(i+1) || err !== 1'b0) begin failures++; $display("FAIL inc_write got=%b/%0d/%0d/%b exp=1/5/%0d/0", bus.w_v, bus.w_wg, bus.w_val, err, i+1); end
      end
      @(negedge clk); clear_req(); #1;
      checks++; if (bus.req_ready !== 3'b000) begin failures++; $display("FAIL idle_ready got=%b exp=000", bus.req_ready); end
      @(negedge clk);
      checks++; if (pending !== 1'b1 || bus.w_v !== 1'b0) begin failures++; $display("FAIL inc_pending got=%b/%b exp=1/0", pending, bus.w_v); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); clear_req(); set_req(0, 6'd5, 2'd1);
         @(posedge clk); #1;
         checks++; if (bus.w_val !== 3'(2-i) || err !== 1'b0) begin failures++; $display("FAIL dec_write got=%0d/%b exp=%0d/0", bus.w_val, err, 2-i); end
      end
      @(negedge clk); clear_req();
      @(negedge clk);
      checks++; if (pending !== 1'b0) begin failures++; $display("FAIL dec_pending got=%b exp=0", pending); end
   endtask

   task automatic test_round_robin();
      @(negedge clk); clear_req(); set_req(2, 6'd20, 2'd2);
      @(negedge clk); clear_req();
      set_req(0, 6'd30, 2'd2); set_req(1, 6'd31, 2'd2); set_req(2, 6'd32, 2'd2);
      for (int i = 0; i < 6; i++) begin
         #1;
         checks++; if (bus.req_ready !== 3'(1 << (i % 3))) begin failures++; $display("FAIL rr_all got=%b exp=%b", bus.req_ready, 3'(1 << (i % 3))); end
         @(negedge clk);
      end
      bus.req_v[1] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++; if (bus.req_ready !== ((i % 2 == 0) ? 3'b001 : 3'b100)) begin failures++; $display("FAIL rr_drop1 got=%b exp=%b", bus.req_ready, (i % 2 == 0) ? 3'b001 : 3'b100); end
         @(negedge clk);
      end
      clear_req();
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 8; i++) begin
         @(negedge clk); clear_req(); set_req(0, 6'd9, 2'd0);
         @(posedge clk); #1;
         checks++; if (bus.w_val !== ((i < 7) ? 3'(i+1) : 3'd7) || err !== (i == 7)) begin failures++; $display("FAIL sat_inc got=%0d/%b exp=%0d/%b", bus.w_val, err, (i < 7) ? i+1 : 7, i == 7); end
      end
      @(negedge clk); clear_req(); set_req(0, 6'd10, 2'd1);
      @(posedge clk); #1;
      checks++; if (bus.w_wg !== 6'd10 || bus.w_val !== 3'd0 || err !== 1'b1) begin failures++; $display("FAIL sat_dec got=%0d/%0d/%b exp=10/0/1", bus.w_wg, bus.w_val, err); end
      @(negedge clk); clear_req(); set_req(0, 6'd9, 2'd3);
      @(posedge clk); #1;
      checks++; if (bus.w_v !== 1'b1 || bus.w_val !== 3'd7 || err !== 1'b1) begin failures++; $display("FAIL reserved got=%b/%0d/%b exp=1/7/1", bus.w_v, bus.w_val, err); end
      @(negedge clk); clear_req();
      @(posedge clk); #1;
      checks++; if (err !== 1'b0 || bus.w_v !== 1'b0) begin failures++; $display("FAIL err_pulse got=%b/%b exp=0/0", err, bus.w_v); end
   endtask

   task automatic test_bypass();
      rd_wg = 6'd3;
      @(negedge clk); clear_req(); set_req(0, 6'd3, 2'd0);
      @(posedge clk); #1;
      checks++; if (bus.w_val !== 3'd1) begin failures++; $display("FAIL byp_write got=%0d exp=1", bus.w_val); end
      checks++; if (pending !== byp_exp) begin failures++; $display("FAIL byp_same_cycle got=%b exp=%b", pending, byp_exp); end
      @(negedge clk); clear_req();
      @(posedge clk); #1;
      checks++; if (pending !== 1'b1) begin failures++; $display("FAIL byp_next_cycle got=%b exp=1", pending); end
   endtask

   task automatic test_contention();
      @(negedge clk); clear_req(); set_req(2, 6'd21, 2'd2);
      @(negedge clk); clear_req();
      set_req(0, 6'd12, 2'd0); set_req(1, 6'd12, 2'd1); #1;
      checks++; if (bus.req_ready !== 3'b001) begin failures++; $display("FAIL cont_grant0 got=%b exp=001", bus.req_ready); end
      @(posedge clk); #1;
      checks++; if (bus.w_wg !== 6'd12 || bus.w_val !== 3'd1 || err !== 1'b0) begin failures++; $display("FAIL cont_inc got=%0d/%0d/%b exp=12/1/0", bus.w_wg, bus.w_val, err); end
      @(negedge clk); bus.req_v[0] = 1'b0; #1;
      checks++; if (bus.req_ready !== 3'b010) begin failures++; $display("FAIL cont_grant1 got=%b exp=010", bus.req_ready); end
      @(posedge clk); #1;
      checks++; if (bus.w_wg !== 6'd12 || bus.w_val !== 3'd0 || err !== 1'b0) begin failures++; $display("FAIL cont_dec got=%0d/%0d/%b exp=12/0/0", bus.w_wg, bus.w_val, err); end
      @(negedge clk); clear_req();
      @(negedge clk); rd_wg = 6'd12; #1;
      checks++; if (pending !== 1'b0) begin failures++; $display("FAIL cont_pending got=%b exp=0", pending); end
   endtask

   task automatic test_reset_mid_op();
      int cnt;
      @(negedge clk); clear_req(); set_req(0, 6'd9, 2'd1);
      @(posedge clk); #1;
      checks++; if (bus.w_v !== 1'b1 || bus.w_val !== 3'd6) begin failures++; $display("FAIL midop_s1 got=%b/%0d exp=1/6", bus.w_v, bus.w_val); end
      reset_n = 1'b0; #1;
      checks++; if (bus.w_v !== 1'b0 || init_done !== 1'b0 || bus.req_ready !== 3'b000) begin failures++; $display("FAIL midop_drop got=%b/%b/%b exp=0/0/000", bus.w_v, init_done, bus.req_ready); end
      clear_req();
      @(negedge clk); reset_n = 1'b1;
      wait_init(cnt);
      checks++; if (cnt !== 64) begin failures++; $display("FAIL midop_init_len got=%0d exp=64", cnt); end
      rd_wg = 6'd9; #1;
      checks++; if (pending !== 1'b0) begin failures++; $display("FAIL midop_swept got=%b exp=0", pending); end
   endtask

   initial begin
      test_reset();
      test_inc_dec();
      test_round_robin();
      test_saturation();
      test_bypass();
      test_contention();
      test_reset_mid_op();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
